mul_unit: RTL

Parametrised iterative multiplier for the pipelined CPU's execute stage. It runs on the system clock, so the separate fast multiplier clock and its PLL output are no longer needed. It adds a start/done handshake, a signed/unsigned mode, configurable operand width and bits retired per cycle, and a flush input. The execute stage stalls on `Busy` and captures `Produto` on `Done`.

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_partial.sv | 15 +
 rtl/mul_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state encoding and configuration legality check for mul_unit.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    function automatic bit mul_cfg_ok(input int width, input int bpc);
        return width >= 4 && width % 2 == 0 && (bpc == 1 || bpc == 2 || bpc == 4) && width % bpc == 0;
    endfunction

endpackage

// File: rtl/mul_partial.sv
// mul_partial: combinational BPC x WIDTH partial-product generator.
module mul_partial
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [BPC-1:0]       b_bits,
    output logic [WIDTH+BPC-1:0] pp
);

    assign pp = (WIDTH + BPC)'(a) * (WIDTH + BPC)'(b_bits);

endmodule

// File: rtl/mul_unit.sv
// mul_unit: iterative signed/unsigned multiplier with start/done handshake and flush.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic               CLK,
    input  logic               Rst,
    input  logic               St,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   Multiplicando,
    input  logic [WIDTH-1:0]   Multiplicador,
    input  logic               Flush,
    output logic               Idle,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Produto
);

    localparam int NCYC = WIDTH / BPC;
    localparam int CW   = $clog2(NCYC + 1);

    mul_state_e           state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, prod_q, prod_d, pp_sh, sum;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH+BPC-1:0] pp;

    if (!mul_cfg_ok(WIDTH, BPC)) begin : g_cfg_check
        $error("mul_unit: WIDTH must be even, >= 4 and divisible by BPC in {1,2,4}");
    end

    // Magnitude as an unsigned WIDTH-bit value; the most-negative input maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    mul_partial #(.WIDTH(WIDTH), .BPC(BPC)) u_partial (
        .a      (a_q),
        .b_bits (b_q[BPC-1:0]),
        .pp     (pp)
    );

    assign pp_sh = (2 * WIDTH)'(pp) << ((NCYC - int'(cnt_q)) * BPC);
    assign sum   = acc_q + pp_sh;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        if (Flush) begin
            state_d = MUL_IDLE;
        end else begin
            case (state_q)
                MUL_IDLE: if (St) begin
                    a_d     = mag(Multiplicando, Signed);
                    b_d     = mag(Multiplicador, Signed);
                    neg_d   = Signed & (Multiplicando[WIDTH-1] ^ Multiplicador[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = CW'(NCYC);
                    state_d = MUL_RUN;
                end
                MUL_RUN: begin
                    acc_d = sum;
                    b_d   = b_q >> BPC;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        prod_d  = neg_q ? -sum : sum;
                        state_d = MUL_DONE;
                    end
                end
                default: state_d = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_q <= MUL_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign Idle    = state_q == MUL_IDLE;
    assign Busy    = state_q == MUL_RUN;
    assign Done    = state_q == MUL_DONE;
    assign Produto = prod_q;

endmodule
